// File: rtl/addsub_serial_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_serial_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation encoding on the op input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // 1-bit full-adder cell: returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/addsub_serial_slice.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Optionally inverts b (subtract); also reports the carry into the MSB
// so the caller can form signed overflow.
module addsub_slice
    import addsub_serial_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic       carry;
    logic [1:0] fa;

    // Ripple through the cells LSB first; cmsb ends up as the carry into bit DIGIT-1
    always_comb begin
        carry = cin;
        cmsb  = cin;
        fa    = 2'b00;
        s     = '0;
        for (int i = 0; i < DIGIT; i++) begin
            cmsb  = carry;
            fa    = full_add(a[i], b[i] ^ sub, carry);
            s[i]  = fa[0];
            carry = fa[1];
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract: WIDTH-bit operands processed DIGIT bits per
// clock, LSB first, with a registered carry between slices.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = $clog2(NSLICE) + 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t               state;
    logic [WIDTH-1:0]     a_q, b_q, res_q;
    logic                 op_q, carry_q;
    logic                 co_q, ovf_q, busy_q, done_q;
    logic [CW-1:0]        cnt, cnt_inc;
    logic                 ready;

    logic [DIGIT-1:0]     sl_sum;
    logic                 sl_cout, sl_cmsb;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic                 cnt_cout_unused, cnt_cmsb_unused;

    assign ready   = (state != RUN);
    assign res_cat = {sl_sum, res_q};

    // Datapath slice: low DIGIT bits of the shifting operand registers
    addsub_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .sub  (op_q),
        .cin  (carry_q),
        .s    (sl_sum),
        .cout (sl_cout),
        .cmsb (sl_cmsb)
    );

    // Digit counter increment reuses the same adder cell
    addsub_slice #(.DIGIT(CW)) u_cnt_inc (
        .a    (cnt),
        .b    ({CW{1'b0}}),
        .sub  (1'b0),
        .cin  (1'b1),
        .s    (cnt_inc),
        .cout (cnt_cout_unused),
        .cmsb (cnt_cmsb_unused)
    );

    // Controller and datapath registers; all outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            cnt     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!ready) begin
            // RUN: consume one slice, shift result in from the MSB end
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            res_q   <= res_cat[WIDTH+DIGIT-1:DIGIT];
            carry_q <= sl_cout;
            cnt     <= cnt_inc;
            if (cnt == LAST) begin
                state  <= DONE;
                co_q   <= sl_cout;
                ovf_q  <= sl_cmsb ^ sl_cout;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else if (start) begin
            // IDLE/DONE acceptance; subtract seeds the carry with 1 (two's complement)
            state   <= RUN;
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= (op == OP_SUB);
            cnt     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state  <= IDLE;
            done_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = res_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench: two instances (DIGIT=1 and DIGIT=4, WIDTH=8) checked
// against a plain-arithmetic reference model.
module tb_addsub_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [2];
    logic       op_v    [2];
    logic [7:0] a_v     [2];
    logic [7:0] b_v     [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic [7:0] sum_v   [2];
    logic       co_v    [2];
    logic       ovf_v   [2];

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op_v[0]),
        .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .sum(sum_v[0]), .co(co_v[0]), .ovf(ovf_v[0])
    );

    addsub_serial #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op_v[1]),
        .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .sum(sum_v[1]), .co(co_v[1]), .ovf(ovf_v[1])
    );

    // Reference: {co, ovf, sum} from integer arithmetic
    function automatic logic [9:0] ref_calc(input logic [7:0] x, input logic [7:0] y, input logic o);
        int sx, sy, sr, ur;
        logic c, v;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (o) begin
            ur = int'(x) - int'(y);
            sr = sx - sy;
            c  = (x >= y);
        end else begin
            ur = int'(x) + int'(y);
            sr = sx + sy;
            c  = (ur > 255);
        end
        v = (sr > 127) || (sr < -128);
        return {c, v, 8'(ur)};
    endfunction

    function automatic logic [31:0] outs(input int d);
        return {20'd0, busy_v[d], done_v[d], co_v[d], ovf_v[d], sum_v[d]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: checks busy, latency, result and hold after done
    task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                          input logic opv, input string tag);
        int cnt;
        int lat;
        logic [9:0] e;
        lat = (d == 0) ? 9 : 3;
        e = ref_calc(av, bv, opv);
        a_v[d] = av; b_v[d] = bv; op_v[d] = opv; start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        chk({tag, "_busy"}, 32'(busy_v[d]), 32'd1);
        a_v[d] = 8'($urandom); b_v[d] = 8'($urandom); op_v[d] = 1'($urandom);
        cnt = 1;
        while (!done_v[d] && cnt < 40) begin
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'(lat));
        chk({tag, "_result"}, {22'd0, co_v[d], ovf_v[d], sum_v[d]}, {22'd0, e});
        tick();
        chk({tag, "_hold"}, {21'd0, done_v[d], co_v[d], ovf_v[d], sum_v[d]}, {21'd0, 1'b0, e});
    endtask

    initial begin
        int dcnt;
        int cnt;
        logic [7:0] cap;
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic       qo[$];
        logic [9:0] e;

        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; op_v[d] = 1'b0; a_v[d] = 8'h00; b_v[d] = 8'h00;
        end

        // Reset state
        #12;
        chk("reset_d1", outs(0), 32'd0);
        chk("reset_d4", outs(1), 32'd0);

        // Release reset and start on the very first rising edge
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(0, 8'h7F, 8'h01, 1'b0, "add_7f_01");
        chk("add_7f_01_exact", {23'd0, co_v[0], ovf_v[0], sum_v[0]}, {23'd0, 1'b0, 1'b1, 8'h80});
        run_op(0, 8'hFF, 8'h01, 1'b0, "add_ff_01");
        chk("add_ff_01_exact", {23'd0, co_v[0], ovf_v[0], sum_v[0]}, {23'd0, 1'b1, 1'b0, 8'h00});
        run_op(1, 8'h05, 8'h07, 1'b1, "sub4_05_07");
        chk("sub4_05_07_exact", {23'd0, co_v[1], ovf_v[1], sum_v[1]}, {23'd0, 1'b0, 1'b0, 8'hFE});
        run_op(0, 8'h80, 8'h01, 1'b1, "sub_80_01");
        run_op(1, 8'h7F, 8'h80, 1'b1, "sub4_7f_80");
        run_op(0, 8'h00, 8'h00, 1'b1, "sub_00_00");

        // start pulsed mid-RUN must be ignored
        a_v[0] = 8'h20; b_v[0] = 8'h03; op_v[0] = 1'b0; start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        dcnt = 0;
        cap = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin a_v[0] = 8'h11; start_v[0] = 1'b1; end
            if (i == 4) start_v[0] = 1'b0;
            tick();
            if (done_v[0]) begin dcnt++; cap = sum_v[0]; end
        end
        chk("midrun_done_count", 32'(dcnt), 32'd1);
        chk("midrun_result", 32'(cap), 32'h23);

        // Reset asserted in the 4th RUN cycle aborts without done
        a_v[0] = 8'h55; b_v[0] = 8'h33; op_v[0] = 1'b0; start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("abort_pre_busy", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", outs(0), 32'd0);
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_v[0]) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        run_op(0, 8'h01, 8'h01, 1'b0, "fresh_01_01");
        chk("fresh_sum", 32'(sum_v[0]), 32'h02);

        // Random isolated operations on both instances
        for (int i = 0; i < 6; i++) begin
            run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), "rnd_d1");
            run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), "rnd_d4");
        end

        // start held high: back-to-back operations, one done every 9 cycles
        a_v[0] = 8'($urandom); b_v[0] = 8'($urandom); op_v[0] = 1'($urandom);
        qa.push_back(a_v[0]); qb.push_back(b_v[0]); qo.push_back(op_v[0]);
        start_v[0] = 1'b1;
        tick();
        a_v[0] = 8'($urandom); b_v[0] = 8'($urandom); op_v[0] = 1'($urandom);
        qa.push_back(a_v[0]); qb.push_back(b_v[0]); qo.push_back(op_v[0]);
        for (int k = 0; k < 6; k++) begin
            cnt = 1;
            while (!done_v[0] && cnt < 40) begin
                tick();
                cnt++;
            end
            chk("b2b_period", 32'(cnt), 32'd9);
            e = ref_calc(qa.pop_front(), qb.pop_front(), qo.pop_front());
            chk("b2b_result", {22'd0, co_v[0], ovf_v[0], sum_v[0]}, {22'd0, e});
            tick();
            chk("b2b_reaccept_busy", 32'(busy_v[0]), 32'd1);
            a_v[0] = 8'($urandom); b_v[0] = 8'($urandom); op_v[0] = 1'($urandom);
            qa.push_back(a_v[0]); qb.push_back(b_v[0]); qo.push_back(op_v[0]);
        end
        start_v[0] = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", ncmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, at least 2.
REQ-002 SHALL have parameter DIGIT, default 1: bits processed per clock; WIDTH mod DIGIT = 0 is required, with elaboration-time error otherwise.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled high while ready = accepted.
REQ-006 SHALL have port op  input  1  0 = a+b, 1 = a-b; captured on acceptance.
REQ-007 SHALL have port a  input  WIDTH  operand A; captured on acceptance.
REQ-008 SHALL have port b  input  WIDTH  operand B; captured on acceptance.
REQ-009 SHALL have port busy  output  1  high while digits are being processed.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port sum  output  WIDTH  result, two's-complement modulo 2^WIDTH.
REQ-012 SHALL have port co  output  1  final carry out; for subtract, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE, with ready = (state != RUN).
REQ-015 IDLE/DONE + start=1 SHALL capture a, b and op, clear the digit counter, load the carry register with op, and go to RUN.
REQ-016 DONE + start=0 SHALL go to IDLE; IDLE + start=0 SHALL stay in IDLE.
REQ-017 Each RUN cycle SHALL add one DIGIT-bit slice, LSB first: A slice + (B slice XOR {DIGIT{op}}) + carry register.
REQ-018 Each RUN cycle SHALL shift the slice result into the result register from the MSB end and register the slice carry out.
REQ-019 RUN SHALL last exactly WIDTH/DIGIT cycles, then go to DONE.
REQ-020 Latency SHALL be WIDTH/DIGIT+1 rising edges from the accepting edge to done=1.
REQ-021 done SHALL be high only in DONE; busy SHALL be high only in RUN.
REQ-022 On the final RUN cycle, co SHALL be registered from the slice carry out, and ovf SHALL be registered from the carry into bit DIGIT-1 of that slice XOR its carry out.
REQ-023 sum, co and ovf SHALL hold their values from the DONE cycle until the next acceptance, and SHALL be stable whenever done=1.
REQ-024 start during RUN SHALL be ignored, with no effect on the operation or the captured operands.
REQ-025 start in the DONE cycle SHALL be accepted (back-to-back), with done still pulsing for exactly that one cycle.
REQ-026 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and busy=0, done=0, sum=0, co=0, ovf=0.
REQ-028 rst_n low SHALL also clear the counter, the carry register and the operand registers.
REQ-029 Reset asserted during RUN SHALL abort the operation without any done pulse; the first start after release SHALL begin a fresh operation.
REQ-030 The first start SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and an op encoding constant (OP_ADD=0, OP_SUB=1).
REQ-032 One sub-module, addsub_slice, SHALL provide the combinational DIGIT-bit ripple adder with carry in, carry out and MSB carry-in outputs, built from 1-bit full-adder cells.
REQ-033 The counter width SHALL be clog2(WIDTH/DIGIT)+1, with no other arithmetic outside addsub_slice.

Verification
REQ-034 The bench SHALL check, at WIDTH=8, DIGIT=1: a=0x7F, b=0x01, op=0 -> done on the 9th edge after acceptance, sum=0x80, co=0, ovf=1.
REQ-035 The bench SHALL check, at WIDTH=8, DIGIT=1: a=0xFF, b=0x01, op=0 -> sum=0x00, co=1, ovf=0.
REQ-036 The bench SHALL check, at WIDTH=8, DIGIT=4: a=0x05, b=0x07, op=1 -> done on the 3rd edge, sum=0xFE, co=0, ovf=0.
REQ-037 The bench SHALL check: start pulsed with a=0x11 mid-RUN of 0x20+0x03 -> result 0x23, and exactly one done pulse.
REQ-038 The bench SHALL check: rst_n low on the 4th RUN cycle -> outputs immediately 0, no done; a fresh 0x01+0x01 then gives sum=0x02.
REQ-039 The bench SHALL check: start held high continuously -> back-to-back operations, with done once every WIDTH/DIGIT+1 cycles and each result correct against a reference model.
